// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared CDB broadcast lane.
// Optional stall counters enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      Hold,
  input  logic [NUM_SRC-1:0]        Req,
  input  logic [NUM_SRC*TAG_W-1:0]  ReqTag,
  input  logic [NUM_SRC*DATA_W-1:0] ReqData,
  input  logic [NUM_SRC-1:0]        ReqWB,
  output logic [NUM_SRC-1:0]        Ready,
  output logic [DATA_W+TAG_W:0]     CDB_Out,
  output logic                      CDB_WB,
  output logic [NUM_SRC*16-1:0]     StallCnt,
  input  logic                      PerfClear
);

  localparam int PW = (NUM_SRC > 1) ?
    $clog2(NUM_SRC) : 1;

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        ptr_nxt;
  logic [NUM_SRC-1:0]   grant;
  logic                 found;
  logic [DATA_W-1:0]    sel_data;
  logic [TAG_W-1:0]     sel_tag;
  logic                 sel_wb;

  // Scan from ptr upward, wrapping; first requester wins.
  always_comb begin
    int s;
    s        = 0;
    grant    = '0;
    found    = 1'b0;
    ptr_nxt  = ptr;
    sel_data = '0;
    sel_tag  = '0;
    sel_wb   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (int'(ptr) + k) % NUM_SRC;
      if (!found && Req[s]) begin
        found    = 1'b1;
        grant[s] = 1'b1;
        sel_data = ReqData[s*DATA_W +: DATA_W];
        sel_tag  = ReqTag[s*TAG_W +: TAG_W];
        sel_wb   = ReqWB[s];
        ptr_nxt  = (s == NUM_SRC - 1) ?
          '0 : PW'(s + 1);
      end
    end
    if (Hold || !Reset) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign Ready = grant;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      CDB_Out <= '0;
      CDB_WB  <= 1'b0;
      ptr     <= '0;
    end else if (found) begin
      CDB_Out <= {sel_data, 1'b1, sel_tag};
      CDB_WB  <= sel_wb;
      ptr     <= ptr_nxt;
    end else begin
      CDB_Out <= '0;
      CDB_WB  <= 1'b0;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [15:0] stall_q [NUM_SRC];

  // Clear beats increment; counters saturate.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_SRC; i++)
        stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (PerfClear)
          stall_q[i] <= '0;
        else if (Req[i] && !grant[i] &&
                 stall_q[i] != 16'hFFFF)
          stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    StallCnt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      StallCnt[i*16 +: 16] = stall_q[i];
  end
`else
  logic unused_perf;
  assign unused_perf = PerfClear;
  assign StallCnt    = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, corner sequences,
// and random traffic against a queue-free reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 32;

  logic            CLK = 1'b0;
  logic            Reset = 1'b0;
  logic            Hold = 1'b0;
  logic            PerfClear = 1'b0;
  logic [N-1:0]    Req = '0;
  logic [N-1:0]    ReqWB = '0;
  logic [N*TW-1:0] ReqTag = '0;
  logic [N*DW-1:0] ReqData = '0;
  logic [N-1:0]    Ready;
  logic [DW+TW:0]  CDB_Out;
  logic            CDB_WB;
  logic [N*16-1:0] StallCnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cdb_arbiter #(
    .NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Hold(Hold),
    .Req(Req), .ReqTag(ReqTag),
    .ReqData(ReqData), .ReqWB(ReqWB),
    .Ready(Ready), .CDB_Out(CDB_Out),
    .CDB_WB(CDB_WB), .StallCnt(StallCnt),
    .PerfClear(PerfClear)
  );

  logic [TW-1:0] tag_a [N];
  logic [DW-1:0] dat_a [N];
  logic          wb_a  [N];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      ReqTag[i*TW +: TW]  = tag_a[i];
      ReqData[i*DW +: DW] = dat_a[i];
      ReqWB[i]            = wb_a[i];
    end
  endtask

  function automatic logic [DW+TW:0] word(int s);
    return {dat_a[s], 1'b1, tag_a[s]};
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic         hold;
    logic [N-1:0] ready;
    logic         valid;
    int           src;
  } vec_t;

  vec_t tbl [12];
  int   bcnt [N];
  int   mptr;
  bit   pend [N];
  int   g;
  logic [DW+TW:0] ecdb;
  logic           ewb;

  initial begin
    tag_a = '{3'd5, 3'd1, 3'd6, 3'd3};
    dat_a = '{32'hDEADBEEF, 32'h11111111,
              32'h22222222, 32'h33333333};
    wb_a  = '{1'b1, 1'b0, 1'b1, 1'b0};
    pack();

    // ptr walk: 0 ->1 ->2 ->1 ->2 ->(hold) ->3 ->0 ->1
    tbl[0]  = '{4'b0001, 0, 4'b0001, 1, 0};
    tbl[1]  = '{4'b0000, 0, 4'b0000, 0, 0};
    tbl[2]  = '{4'b0010, 0, 4'b0010, 1, 1};
    tbl[3]  = '{4'b0011, 0, 4'b0001, 1, 0};
    tbl[4]  = '{4'b0010, 0, 4'b0010, 1, 1};
    tbl[5]  = '{4'b0100, 1, 4'b0000, 0, 0};
    tbl[6]  = '{4'b0100, 1, 4'b0000, 0, 0};
    tbl[7]  = '{4'b0100, 1, 4'b0000, 0, 0};
    tbl[8]  = '{4'b0100, 0, 4'b0100, 1, 2};
    tbl[9]  = '{4'b1001, 0, 4'b1000, 1, 3};
    tbl[10] = '{4'b1001, 0, 4'b0001, 1, 0};
    tbl[11] = '{4'b0000, 0, 4'b0000, 0, 0};

    Req = 4'b1111;
    #1;
    chk("rst_ready", 64'(Ready), 64'(0));
    chk("rst_cdb", 64'(CDB_Out), 64'(0));
    chk("rst_wb", 64'(CDB_WB), 64'(0));
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b1;
    Req = '0;
    @(posedge CLK); #1;

    foreach (tbl[i]) begin
      Req  = tbl[i].req;
      Hold = tbl[i].hold;
      #1;
      chk($sformatf("tbl%0d_ready", i),
          64'(Ready), 64'(tbl[i].ready));
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_cdb", i), 64'(CDB_Out),
          tbl[i].valid ? 64'(word(tbl[i].src)) : 64'(0));
      chk($sformatf("tbl%0d_wb", i), 64'(CDB_WB),
          tbl[i].valid ? 64'(wb_a[tbl[i].src]) : 64'(0));
    end

    // Async reset while a broadcast is on the lane.
    Req = 4'b1111;
    @(posedge CLK); #1;
    chk("pre_rst_valid", 64'(CDB_Out[TW]), 64'(1));
    #2 Reset = 1'b0;
    #1;
    chk("arst_cdb", 64'(CDB_Out), 64'(0));
    chk("arst_ready", 64'(Ready), 64'(0));
    #1 Reset = 1'b1;
    #1;
    chk("post_rst_ready", 64'(Ready), 64'(1));

    // Full contention: strict rotation from source 0.
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 64'(Ready),
          64'(4'(1) << (k % N)));
      @(posedge CLK); #1;
      chk($sformatf("rr%0d_cdb", k), 64'(CDB_Out),
          64'(word(k % N)));
      for (int i = 0; i < N; i++)
        if (CDB_Out[TW] && CDB_Out[TW-1:0] == tag_a[i])
          bcnt[i]++;
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("rr_cnt%0d", i), 64'(bcnt[i]), 64'(2));

    // Random traffic vs. reference model; ptr is back at 0.
    Req  = '0;
    Hold = 1'b0;
    mptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1;
          tag_a[i] = TW'($urandom);
          dat_a[i] = $urandom;
          wb_a[i]  = 1'($urandom);
        end
        Req[i] = pend[i];
      end
      Hold = ($urandom_range(0, 4) == 0);
      pack();
      #1;
      g = -1;
      if (!Hold)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(mptr + k) % N])
            g = (mptr + k) % N;
      chk($sformatf("rnd%0d_ready", c), 64'(Ready),
          (g < 0) ? 64'(0) : 64'(4'(1) << g));
      ecdb = '0;
      ewb  = 1'b0;
      if (g >= 0) begin
        ecdb    = word(g);
        ewb     = wb_a[g];
        pend[g] = 0;
        mptr    = (g + 1) % N;
      end
      @(posedge CLK); #1;
      chk($sformatf("rnd%0d_cdb", c), 64'(CDB_Out),
          64'(ecdb));
      chk($sformatf("rnd%0d_wb", c), 64'(CDB_WB),
          64'(ewb));
    end

`ifdef CDB_ARB_PERF_EN
    Req = '0;
    Hold = 1'b0;
    #1 Reset = 1'b0;
    #1 Reset = 1'b1;
    @(posedge CLK); #1;
    Req = 4'b1111;
    repeat (3) @(posedge CLK);
    #1;
    chk("perf_ready3", 64'(Ready), 64'(4'b1000));
    chk("perf_cnt3", 64'(StallCnt[3*16 +: 16]), 64'(3));
    Req  = 4'b1000;
    Hold = 1'b1;
    repeat (65540) @(posedge CLK);
    #1;
    chk("perf_sat", 64'(StallCnt[3*16 +: 16]),
        64'(16'hFFFF));
    PerfClear = 1'b1;
    @(posedge CLK); #1;
    PerfClear = 1'b0;
    chk("perf_clr", 64'(StallCnt), 64'(0));
`else
    Req = 4'b1111;
    Hold = 1'b1;
    PerfClear = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("perf_off", 64'(StallCnt), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
